data_mem_arbiter: RTL and testbench

Shares the single data-memory port between two requesters: the pipelined processor's load/store stage and a debug/loader port used by benches and board tooling to read or patch memory. Each request is granted, forwarded to memory with the command held stable until the memory signals completion, and answered with a one-cycle completion indication. While its access is pending, the processor is held with a stall. It sits between the `Pipelined_Processor` memory signals and the external data memory.

---
 rtl/data_mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares one data-memory port between the processor load/store stage and a
// debug/loader port. An access is granted from IDLE and its command is held on
// mem_* until mem_ready. Completion is a one-cycle cpu_done (internal) or dbg_ack.
// Optional feature: define DATA_MEM_ARB_RR_EN for round-robin tie-breaking.
// Without it, the CPU always wins a tie.
//
// Handshake on the memory side:
//   mem_req is valid and mem_ready is ready. A command is presented with mem_req=1.
//   mem_we, mem_addr and mem_wdata stay frozen until mem_ready=1 is sampled on a
//   rising edge; that edge completes the access. mem_rdata is only looked at on
//   that same edge. mem_ready is ignored whenever mem_req=0.
// Requester side:
//   The CPU holds cpu_rd/cpu_wr while cpu_stall=1. It advances at the end of the
//   first cycle with cpu_stall=0.
//   Debug holds dbg_req until it sees the dbg_ack pulse.
module data_mem_arbiter #(
   parameter int DataWidth = 16,
   parameter int AddrWidth = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 cpu_rd,
   input  logic                 cpu_wr,
   input  logic [AddrWidth-1:0] cpu_addr,
   input  logic [DataWidth-1:0] cpu_wdata,
   output logic [DataWidth-1:0] cpu_rdata,
   output logic                 cpu_stall,
   input  logic                 dbg_req,
   input  logic                 dbg_we,
   input  logic [AddrWidth-1:0] dbg_addr,
   input  logic [DataWidth-1:0] dbg_wdata,
   output logic                 dbg_ack,
   output logic [DataWidth-1:0] dbg_rdata,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [AddrWidth-1:0] mem_addr,
   output logic [DataWidth-1:0] mem_wdata,
   input  logic [DataWidth-1:0] mem_rdata,
   input  logic                 mem_ready,
   output logic [1:0]           fsm_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CPU  = 2'd1,
      DBG  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic                 mem_req_q, mem_req_d;
   logic                 mem_we_q, mem_we_d;
   logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
   logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
   logic [DataWidth-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DataWidth-1:0] dbg_rdata_q, dbg_rdata_d;
   logic                 dbg_ack_q, dbg_ack_d;
   logic                 cpu_done_q, cpu_done_d;

   logic cpu_pend;
   logic dbg_pend;
   logic cpu_wins_tie;
   logic grant_cpu;
   logic grant_dbg;
   logic mem_done;

   // A requester is masked in its own completion cycle. This keeps a still-held
   // request from being granted a second time.
   assign cpu_pend = (cpu_rd | cpu_wr) & ~cpu_done_q;
   assign dbg_pend = dbg_req & ~dbg_ack_q;

`ifdef DATA_MEM_ARB_RR_EN
   // rr_last_cpu_q = 1 means the most recent grant went to the CPU.
   // Its reset value 0 lets the CPU win the first tie.
   logic rr_last_cpu_q, rr_last_cpu_d;

   assign cpu_wins_tie = ~rr_last_cpu_q;

   // Pointer update: record the owner of every grant.
   always_comb begin
      rr_last_cpu_d = rr_last_cpu_q;
      if (grant_cpu) begin
         rr_last_cpu_d = 1'b1;
      end else if (grant_dbg) begin
         rr_last_cpu_d = 1'b0;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rr_last_cpu_q <= 1'b0;
      end else begin
         rr_last_cpu_q <= rr_last_cpu_d;
      end
   end
`else
   // Fixed priority: the CPU takes every tie. Debug may wait behind the CPU.
   assign cpu_wins_tie = 1'b1;
`endif

   // Grants are only issued from IDLE.
   assign grant_cpu = (state_q == IDLE) & cpu_pend & (~dbg_pend | cpu_wins_tie);
   assign grant_dbg = (state_q == IDLE) & dbg_pend & ~grant_cpu;

   // The access completes on the edge where mem_ready is seen with a live command.
   assign mem_done = mem_req_q & mem_ready;

   // Next-state and datapath: latch the command on grant, then return data on completion.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      dbg_ack_d   = 1'b0;
      cpu_done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_cpu) begin
               // A simultaneous rd+wr is treated as a write.
               state_d     = CPU;
               mem_req_d   = 1'b1;
               mem_we_d    = cpu_wr;
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_wdata;
            end else if (grant_dbg) begin
               state_d     = DBG;
               mem_req_d   = 1'b1;
               mem_we_d    = dbg_we;
               mem_addr_d  = dbg_addr;
               mem_wdata_d = dbg_wdata;
            end
         end
         CPU: begin
            if (mem_done) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               cpu_done_d = 1'b1;
               if (!mem_we_q) begin
                  cpu_rdata_d = mem_rdata;
               end
            end
         end
         DBG: begin
            if (mem_done) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               dbg_ack_d = 1'b1;
               if (!mem_we_q) begin
                  dbg_rdata_d = mem_rdata;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers. An asynchronous reset abandons any access in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
         dbg_ack_q   <= 1'b0;
         cpu_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
         dbg_ack_q   <= dbg_ack_d;
         cpu_done_q  <= cpu_done_d;
      end
   end

   // The stall covers the whole wait, including time spent behind a debug access.
   assign cpu_stall   = cpu_pend;
   assign cpu_rdata   = cpu_rdata_q;
   assign dbg_ack     = dbg_ack_q;
   assign dbg_rdata   = dbg_rdata_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign fsm_state_o = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vectors with a memory model.
// A negedge monitor checks memory commands, CPU completions and debug acks
// against expected queues.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        cpu_rd, cpu_wr;
   logic [15:0] cpu_addr, cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_stall;
   logic        dbg_req, dbg_we;
   logic [15:0] dbg_addr, dbg_wdata;
   logic        dbg_ack;
   logic [15:0] dbg_rdata;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = 16'hDEAD;
   logic        mem_ready = 1'b0;
   logic [1:0]  fsm_state_o;

   data_mem_arbiter #(.DataWidth(16), .AddrWidth(16)) dut (
      .CLK(CLK), .RST(RST),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .fsm_state_o(fsm_state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   // ---------------- scoreboard state ----------------
   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   logic [34:0] exp_cmd_q[$];   // {owner state, we, addr, wdata}
   logic [15:0] exp_cpu_q[$];
   logic [15:0] exp_dbg_q[$];
   logic [15:0] model_mem[256];
   int          mem_w    = 0;
   int          wait_cnt = 0;
   bit          spurious = 1'b0;
   logic [34:0] mon_cmd;
   logic [15:0] mon_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- memory model + monitor ----------------
   always @(negedge CLK) begin
      if (RST) begin
         mem_ready = 1'b0;
         wait_cnt  = 0;
         mem_rdata = 16'hDEAD;
      end else begin
         if (mem_req) begin
            mem_ready = (wait_cnt == mem_w);
            mem_rdata = mem_ready ? model_mem[mem_addr[7:0]] : 16'hDEAD;
            if (mem_ready) begin
               chk("mem_cmd_expected", 64'(exp_cmd_q.size() != 0), 64'd1);
               if (exp_cmd_q.size() != 0) begin
                  mon_cmd = exp_cmd_q.pop_front();
                  chk("mem_cmd", {fsm_state_o, mem_we, mem_addr, mem_wdata}, mon_cmd);
               end
               if (mem_we) model_mem[mem_addr[7:0]] = mem_wdata;
            end
            wait_cnt++;
         end else begin
            wait_cnt  = 0;
            mem_ready = spurious;
            mem_rdata = 16'hDEAD;
         end
         if ((cpu_rd | cpu_wr) && !cpu_stall) begin
            chk("cpu_done_expected", 64'(exp_cpu_q.size() != 0), 64'd1);
            if (exp_cpu_q.size() != 0) begin
               mon_data = exp_cpu_q.pop_front();
               chk("cpu_rdata", cpu_rdata, mon_data);
            end
         end
         if (dbg_ack) begin
            chk("dbg_ack_expected", 64'(exp_dbg_q.size() != 0), 64'd1);
            if (exp_dbg_q.size() != 0) begin
               mon_data = exp_dbg_q.pop_front();
               chk("dbg_rdata", dbg_rdata, mon_data);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   task automatic cpu_access(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] exp_rd, input int w);
      bit seen = 1'b0;
      mem_w = w;
      next_cycle();
      cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
      exp_cmd_q.push_back({2'd1, wr, addr, wdata});
      exp_cpu_q.push_back(exp_rd);
      for (int i = 0; i < 32 && !seen; i++) begin
         sample();
         if (!cpu_stall) seen = 1'b1;
         else next_cycle();
      end
      chk("cpu_access_done_seen", 64'(seen), 64'd1);
      next_cycle();
      cpu_rd = 1'b0; cpu_wr = 1'b0;
   endtask

   task automatic dbg_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] exp_rd, input int w);
      bit seen = 1'b0;
      mem_w = w;
      next_cycle();
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      exp_cmd_q.push_back({2'd2, we, addr, wdata});
      exp_dbg_q.push_back(exp_rd);
      for (int i = 0; i < 32 && !seen; i++) begin
         sample();
         if (dbg_ack) seen = 1'b1;
         else next_cycle();
      end
      chk("dbg_access_ack_seen", 64'(seen), 64'd1);
      next_cycle();
      dbg_req = 1'b0; dbg_we = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int  stall_cnt;
   int  ack_cnt;
   bit  cpu_first;

   initial begin
      RST = 1'b1;
      cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
      model_mem[8'h10] = 16'hBEEF;
      model_mem[8'h20] = 16'h1111;
      model_mem[8'h30] = 16'h2222;
      model_mem[8'h40] = 16'h4444;

      // reset values
      next_cycle();
      sample();
      chk("reset_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 64'd0);
      chk("reset_regs", {cpu_rdata, dbg_rdata, dbg_ack, cpu_stall, fsm_state_o}, 64'd0);
      next_cycle();
      RST = 1'b0;
      next_cycle();

      // T1: zero-wait CPU read of 0x0010 -> 0xBEEF
      mem_w = 0;
      stall_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) next_cycle();
         if (c == 0) begin
            cpu_rd = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h0000;
            exp_cmd_q.push_back({2'd1, 1'b0, 16'h0010, 16'h0000});
            exp_cpu_q.push_back(16'hBEEF);
         end
         if (c == 3) cpu_rd = 1'b0;
         sample();
         stall_cnt += int'(cpu_stall);
         chk($sformatf("t1_mem_req_c%0d", c), 64'(mem_req), 64'(c == 1));
         if (c == 2) chk("t1_cpu_rdata_c2", cpu_rdata, 64'hBEEF);
      end
      chk("t1_stall_cycles", 64'(stall_cnt), 64'd2);

      // T2: W=3 debug write 0x1234 -> 0x0005
      next_cycle(); next_cycle();
      mem_w = 3;
      ack_cnt = 0;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) next_cycle();
         if (c == 0) begin
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0005; dbg_wdata = 16'h1234;
            exp_cmd_q.push_back({2'd2, 1'b1, 16'h0005, 16'h1234});
            exp_dbg_q.push_back(16'h0000);
         end
         if (c == 6) begin dbg_req = 1'b0; dbg_we = 1'b0; end
         sample();
         ack_cnt += int'(dbg_ack);
         if (c >= 1 && c <= 4)
            chk($sformatf("t2_cmd_stable_c%0d", c), {mem_req, mem_we, mem_addr, mem_wdata},
                {1'b1, 1'b1, 16'h0005, 16'h1234});
         if (c == 5) chk("t2_ack_c5", 64'(dbg_ack), 64'd1);
      end
      chk("t2_ack_count", 64'(ack_cnt), 64'd1);
      chk("t2_dbg_rdata_kept", dbg_rdata, 64'h0000);

      // T3: debug read-back of the written word
      dbg_access(1'b0, 16'h0005, 16'h0000, 16'h1234, 1);

      // T4: simultaneous requests, both held and repeating: C, D, C, D
      mem_w = 0;
      next_cycle();
      cpu_rd = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h0000;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0030; dbg_wdata = 16'h0000;
      exp_cmd_q.push_back({2'd1, 1'b0, 16'h0020, 16'h0000});
      exp_cmd_q.push_back({2'd2, 1'b0, 16'h0030, 16'h0000});
      exp_cmd_q.push_back({2'd1, 1'b0, 16'h0020, 16'h0000});
      exp_cmd_q.push_back({2'd2, 1'b0, 16'h0030, 16'h0000});
      exp_cpu_q.push_back(16'h1111); exp_cpu_q.push_back(16'h1111);
      exp_dbg_q.push_back(16'h2222); exp_dbg_q.push_back(16'h2222);
      for (int c = 0; c < 10; c++) begin
         if (c > 0) next_cycle();
         if (c == 7) cpu_rd = 1'b0;
         if (c == 9) dbg_req = 1'b0;
         sample();
         if (c == 1 || c == 5) chk($sformatf("t4_owner_c%0d", c), 64'(fsm_state_o), 64'd1);
         if (c == 3 || c == 7) chk($sformatf("t4_owner_c%0d", c), 64'(fsm_state_o), 64'd2);
      end

      // T5: CPU access alone, then a fresh tie (fixed: CPU wins, RR: debug wins)
      cpu_access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h4444, 0);
`ifdef DATA_MEM_ARB_RR_EN
      cpu_first = 1'b0;
`else
      cpu_first = 1'b1;
`endif
      next_cycle();
      cpu_rd = 1'b1; cpu_addr = 16'h0020;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0030;
      if (cpu_first) begin
         exp_cmd_q.push_back({2'd1, 1'b0, 16'h0020, 16'h0000});
         exp_cmd_q.push_back({2'd2, 1'b0, 16'h0030, 16'h0000});
      end else begin
         exp_cmd_q.push_back({2'd2, 1'b0, 16'h0030, 16'h0000});
         exp_cmd_q.push_back({2'd1, 1'b0, 16'h0020, 16'h0000});
      end
      exp_cpu_q.push_back(16'h1111);
      exp_dbg_q.push_back(16'h2222);
      for (int c = 0; c < 6; c++) begin
         if (c > 0) next_cycle();
         if (c == 3) begin
            if (cpu_first) cpu_rd = 1'b0; else dbg_req = 1'b0;
         end
         if (c == 5) begin
            cpu_rd = 1'b0; dbg_req = 1'b0;
         end
         sample();
         if (c == 1) chk("t5_tie_winner", 64'(fsm_state_o), cpu_first ? 64'd1 : 64'd2);
         if (c == 3) chk("t5_tie_loser", 64'(fsm_state_o), cpu_first ? 64'd2 : 64'd1);
      end

      // T6: debug read in flight (W=2) when cpu_rd rises
      next_cycle();
      mem_w = 2;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0030;
      exp_cmd_q.push_back({2'd2, 1'b0, 16'h0030, 16'h0000});
      exp_cmd_q.push_back({2'd1, 1'b0, 16'h0040, 16'h0000});
      exp_dbg_q.push_back(16'h2222);
      exp_cpu_q.push_back(16'h4444);
      for (int c = 0; c < 10; c++) begin
         if (c > 0) next_cycle();
         if (c == 2) begin cpu_rd = 1'b1; cpu_addr = 16'h0040; end
         if (c == 5) dbg_req = 1'b0;
         if (c == 9) cpu_rd = 1'b0;
         sample();
         if (c >= 2 && c <= 4) chk($sformatf("t6_stall_c%0d", c), 64'(cpu_stall), 64'd1);
         if (c == 4) chk("t6_ack_c4", 64'(dbg_ack), 64'd1);
         if (c == 5) chk("t6_cpu_granted", {mem_req, fsm_state_o}, {1'b1, 2'd1});
         if (c == 8) chk("t6_cpu_done", {cpu_stall, cpu_rdata}, {1'b0, 16'h4444});
      end

      // T7: reset while the CPU waits on mem_ready
      next_cycle();
      mem_w = 5;
      cpu_rd = 1'b1; cpu_addr = 16'h0010;
      sample();
      next_cycle();
      sample();
      chk("t7_mem_req_before_reset", 64'(mem_req), 64'd1);
      next_cycle();
      RST = 1'b1;
      #1;
      chk("t7_reset_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 64'd0);
      chk("t7_reset_regs", {cpu_rdata, dbg_rdata, dbg_ack, fsm_state_o}, 64'd0);
      next_cycle();
      RST = 1'b0;
      mem_w = 1;
      exp_cmd_q.push_back({2'd1, 1'b0, 16'h0010, 16'h0000});
      exp_cpu_q.push_back(16'hBEEF);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) next_cycle();
         if (c == 4) cpu_rd = 1'b0;
         sample();
         chk($sformatf("t7_regrant_mem_req_c%0d", c), 64'(mem_req), 64'(c == 1 || c == 2));
         if (c == 1) chk("t7_regrant_owner", 64'(fsm_state_o), 64'd1);
      end

      // T8: rd and wr together act as a write; cpu_rdata keeps 0xBEEF
      cpu_access(1'b1, 1'b1, 16'h0050, 16'h00FF, 16'hBEEF, 0);
      chk("t8_cpu_rdata_kept", cpu_rdata, 64'hBEEF);
      dbg_access(1'b0, 16'h0050, 16'h0000, 16'h00FF, 0);

      // T9: mem_ready while idle is ignored
      next_cycle();
      spurious = 1'b1;
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         sample();
         chk($sformatf("t9_idle_ignores_ready_c%0d", c), {mem_req, dbg_ack, fsm_state_o}, 64'd0);
      end
      spurious = 1'b0;

      // drain and final report
      repeat (3) next_cycle();
      chk("exp_cmd_q_empty", 64'(exp_cmd_q.size()), 64'd0);
      chk("exp_cpu_q_empty", 64'(exp_cpu_q.size()), 64'd0);
      chk("exp_dbg_q_empty", 64'(exp_dbg_q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   // Watchdog: the directed run is far shorter than this.
   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
      $fatal(1);
   end

endmodule
